// File: rtl/uart_tx_dev.sv
// uart_tx_dev: bridge-mapped 8N1 UART transmitter with a 4-entry byte FIFO,
// programmable bit period (DIV+1 cycles) and a drained-level interrupt.
module uart_tx_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        txd
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      state_q;
  logic [1:0]  ctrl_q, rp_q, wp_q;
  logic [15:0] div_q, bcnt_q;
  logic [7:0]  mem_q [4];
  logic [7:0]  shift_q, head;
  logic [2:0]  cnt_q, cnt_d, bit_q;
  logic        ovf_q, txd_q, push, push_ok, pop, full, empty, busy, unused_ok;
  always_comb begin
    full    = cnt_q == 3'd4;
    empty   = cnt_q == 3'd0;
    busy    = state_q != IDLE;
    head    = empty ? 8'd0 : mem_q[rp_q];
    push    = WE && Addr[3:2] == 2'd2;
    // a frame may start from IDLE or straight out of the last STOP cycle
    pop     = ctrl_q[0] && !empty && (state_q == IDLE || (state_q == STOP && bcnt_q == 16'd0));
    push_ok = push && (!full || pop);
    cnt_d   = cnt_q + 3'(push_ok) - 3'(pop);
    Dout    = Addr[3:2] == 2'd0 ? {30'd0, ctrl_q} :
              Addr[3:2] == 2'd1 ? {16'd0, div_q} :
              Addr[3:2] == 2'd2 ? {24'd0, head} :
                                  {25'd0, cnt_q, ovf_q, empty, full, busy};
  end
  assign IRQ       = ctrl_q[1] & empty & ~busy;
  assign txd       = txd_q;
  assign unused_ok = ^{Addr[31:4], Din[31:16]};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ctrl_q <= 2'd0;
      div_q  <= 16'd0;
      rp_q   <= 2'd0;
      wp_q   <= 2'd0;
      cnt_q  <= 3'd0;
      ovf_q  <= 1'b0;
    end else begin
      if (WE && Addr[3:2] == 2'd0) ctrl_q <= Din[1:0];
      if (WE && Addr[3:2] == 2'd1) div_q <= Din[15:0];
      if (WE && Addr[3:2] == 2'd3) ovf_q <= 1'b0;
      else if (push && !push_ok) ovf_q <= 1'b1;
      if (push_ok) wp_q <= wp_q + 2'd1;
      if (pop) rp_q <= rp_q + 2'd1;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push_ok) mem_q[wp_q] <= Din[7:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      txd_q   <= 1'b1;
      shift_q <= 8'd0;
      bcnt_q  <= 16'd0;
      bit_q   <= 3'd0;
    end else begin
      if (bcnt_q != 16'd0) bcnt_q <= bcnt_q - 16'd1;
      case (state_q)
        IDLE:
          if (pop) begin
            state_q <= START;
            shift_q <= head;
            bcnt_q  <= div_q;
            txd_q   <= 1'b0;
          end
        START:
          if (bcnt_q == 16'd0) begin
            state_q <= DATA;
            bit_q   <= 3'd0;
            bcnt_q  <= div_q;
            txd_q   <= shift_q[0];
          end
        DATA:
          if (bcnt_q == 16'd0) begin
            bcnt_q <= div_q;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              txd_q <= shift_q[bit_q + 3'd1];
            end
          end
        STOP:
          if (bcnt_q == 16'd0) begin
            if (pop) begin
              state_q <= START;
              shift_q <= head;
              bcnt_q  <= div_q;
              txd_q   <= 1'b0;
            end else state_q <= IDLE;
          end
        default: state_q <= IDLE;
      endcase
    end
endmodule
